// File: rtl/adc_dc_cal_pkg.sv
// rtl/adc_dc_cal_pkg.sv - shared widths, state encoding and K clamp for the DC-offset calibrator
package adc_dc_cal_pkg;
    localparam int SAMP_W    = 16;
    localparam int ACC_W     = 33;
    localparam int CNT_W     = 17;
    localparam int K_W       = 5;
    localparam int K_MIN_DEF = 4;
    localparam int K_MAX_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACCUM,
        ST_ROUND,
        ST_UPDATE
    } cal_state_e;

    function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k, input int kmin, input int kmax);
        if (int'(k) < kmin) return K_W'(kmin);
        if (int'(k) > kmax) return K_W'(kmax);
        return k;
    endfunction
endpackage

// File: rtl/adc_dc_cal_if.sv
// rtl/adc_dc_cal_if.sv - ADC sample bus in, correction words and path select out
interface adc_dc_cal_if;
    import adc_dc_cal_pkg::*;

    logic                     adc_valid;
    logic signed [SAMP_W-1:0] adc_0a, adc_0b, adc_1a, adc_1b;
    logic signed [SAMP_W-1:0] dcoff_0a, dcoff_0b, dcoff_1a, dcoff_1b;
    logic                     dcoff_load;
    logic                     dcoff_sel;

    modport master (
        output adc_valid, adc_0a, adc_0b, adc_1a, adc_1b,
        input  dcoff_0a, dcoff_0b, dcoff_1a, dcoff_1b, dcoff_load, dcoff_sel
    );

    modport slave (
        input  adc_valid, adc_0a, adc_0b, adc_1a, adc_1b,
        output dcoff_0a, dcoff_0b, dcoff_1a, dcoff_1b, dcoff_load, dcoff_sel
    );
endinterface

// File: rtl/adc_dc_cal_chan.sv
// rtl/adc_dc_cal_chan.sv - one channel: accumulate samples, round the mean, negate and saturate
module adc_dc_cal_chan
    import adc_dc_cal_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic                     rnd_i,
    input  logic [K_W-1:0]           k_i,
    input  logic signed [SAMP_W-1:0] sample_i,
    output logic signed [SAMP_W-1:0] corr_o,
    output logic                     sat_o
);
    localparam logic signed [SAMP_W-1:0] SAMP_MIN = 16'sh8000;
    localparam logic signed [SAMP_W-1:0] SAMP_MAX = 16'sh7FFF;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  rnd_bias, acc_rnd;
    logic signed [SAMP_W-1:0] mean_s;
    logic signed [SAMP_W-1:0] corr_q, corr_d;
    logic                     sat_q, sat_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (en_i)
            acc_d = acc_q + $signed({{(ACC_W-SAMP_W){sample_i[SAMP_W-1]}}, sample_i});

        // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
        rnd_bias = $signed(ACC_W'(1) << (k_i - K_W'(1)));
        acc_rnd  = acc_q + rnd_bias;
        mean_s   = SAMP_W'(acc_rnd >>> k_i);

        corr_d = -mean_s;
        sat_d  = 1'b0;
        if (mean_s == SAMP_MIN) begin
            corr_d = SAMP_MAX;
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            corr_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (rnd_i) begin
                corr_q <= corr_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign corr_o = corr_q;
    assign sat_o  = sat_q;
endmodule

// File: rtl/adc_dc_cal_ctrl.sv
// rtl/adc_dc_cal_ctrl.sv - calibration sequencer: settle, average 2^K samples, load negated means
module adc_dc_cal_ctrl
    import adc_dc_cal_pkg::*;
#(
    parameter int SETTLE_CYC = 64,
    parameter int K_MIN      = K_MIN_DEF,
    parameter int K_MAX      = K_MAX_DEF
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    input  logic           cal_start,
    input  logic           cal_abort,
    input  logic [K_W-1:0] mif_cal_k,
    adc_dc_cal_if.slave    adc_if,
    output logic           cal_busy,
    output logic           cal_done,
    output logic [3:0]     cal_sat
);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

    cal_state_e               state_q;
    logic [15:0]              settle_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         n_last;
    logic [K_W-1:0]           k_q;
    logic signed [SAMP_W-1:0] dcoff_q [4];
    logic                     dcoff_load_q, dcoff_sel_q;
    logic                     cal_busy_q, cal_done_q;
    logic [3:0]               cal_sat_q;

    logic                     chan_clr, chan_en, chan_rnd;
    logic signed [SAMP_W-1:0] samp [4];
    logic signed [SAMP_W-1:0] corr [4];
    logic [3:0]               chan_sat;

    assign n_last   = (CNT_W'(1) << k_q) - CNT_W'(1);
    assign chan_clr = (state_q == ST_IDLE) && cal_start && !cal_abort;
    assign chan_en  = (state_q == ST_ACCUM) && adc_if.adc_valid;
    assign chan_rnd = (state_q == ST_ROUND);

    assign samp[0] = adc_if.adc_0a;
    assign samp[1] = adc_if.adc_0b;
    assign samp[2] = adc_if.adc_1a;
    assign samp[3] = adc_if.adc_1b;

    for (genvar i = 0; i < 4; i++) begin : g_chan
        adc_dc_cal_chan u_chan (
            .clk      (sys_clk),
            .rst_n    (sys_rst_n),
            .clr_i    (chan_clr),
            .en_i     (chan_en),
            .rnd_i    (chan_rnd),
            .k_i      (k_q),
            .sample_i (samp[i]),
            .corr_o   (corr[i]),
            .sat_o    (chan_sat[i])
        );
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            cnt_q        <= '0;
            k_q          <= K_W'(K_MIN);
            dcoff_q      <= '{default: '0};
            dcoff_load_q <= 1'b0;
            dcoff_sel_q  <= 1'b0;
            cal_busy_q   <= 1'b0;
            cal_done_q   <= 1'b0;
            cal_sat_q    <= '0;
        end else begin
            dcoff_load_q <= 1'b0;
            cal_done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cal_start && !cal_abort) begin
                        k_q        <= clamp_k(mif_cal_k, K_MIN, K_MAX);
                        settle_q   <= '0;
                        cnt_q      <= '0;
                        state_q    <= ST_SETTLE;
                        cal_busy_q <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cal_abort) begin
                        state_q    <= ST_IDLE;
                        cal_busy_q <= 1'b0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q <= ST_ACCUM;
                    end else begin
                        settle_q <= settle_q + 16'd1;
                    end
                end
                ST_ACCUM: begin
                    if (cal_abort) begin
                        state_q    <= ST_IDLE;
                        cal_busy_q <= 1'b0;
                    end else if (adc_if.adc_valid) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Leave on the edge that accepts the last sample, not one cycle later.
                        if (cnt_q == n_last) state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (cal_abort) begin
                        state_q    <= ST_IDLE;
                        cal_busy_q <= 1'b0;
                    end else begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    dcoff_q      <= corr;
                    cal_sat_q    <= chan_sat;
                    dcoff_load_q <= 1'b1;
                    cal_done_q   <= 1'b1;
                    dcoff_sel_q  <= 1'b1;
                    cal_busy_q   <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cal_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign adc_if.dcoff_0a   = dcoff_q[0];
    assign adc_if.dcoff_0b   = dcoff_q[1];
    assign adc_if.dcoff_1a   = dcoff_q[2];
    assign adc_if.dcoff_1b   = dcoff_q[3];
    assign adc_if.dcoff_load = dcoff_load_q;
    assign adc_if.dcoff_sel  = dcoff_sel_q;
    assign cal_busy          = cal_busy_q;
    assign cal_done          = cal_done_q;
    assign cal_sat           = cal_sat_q;
endmodule

// File: tb/tb_adc_dc_cal_ctrl.sv
// tb/tb_adc_dc_cal_ctrl.sv - directed self-checking bench with an expected-result scoreboard
module tb_adc_dc_cal_ctrl;
    import adc_dc_cal_pkg::*;

    localparam int S = 64;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       cal_start = 1'b0;
    logic       cal_abort = 1'b0;
    logic [4:0] mif_cal_k = 5'd0;
    logic       cal_busy, cal_done;
    logic [3:0] cal_sat;

    adc_dc_cal_if bus ();

    adc_dc_cal_ctrl #(.SETTLE_CYC(S), .K_MIN(4), .K_MAX(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cal_start (cal_start),
        .cal_abort (cal_abort),
        .mif_cal_k (mif_cal_k),
        .adc_if    (bus),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done),
        .cal_sat   (cal_sat)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [3:0][15:0] corr;
        logic [3:0]       sat;
    } exp_t;

    exp_t sb[$];
    exp_t e_last;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_mean(input longint sum, input int k);
        return (sum + (longint'(1) <<< (k - 1))) >>> k;
    endfunction

    function automatic logic [15:0] model_corr(input longint sum, input int k);
        longint m = model_mean(sum, k);
        if (m == -32768) return 16'h7FFF;
        return 16'(-m);
    endfunction

    function automatic longint dcoff(input int i);
        case (i)
            0: return longint'(bus.dcoff_0a);
            1: return longint'(bus.dcoff_0b);
            2: return longint'(bus.dcoff_1a);
            default: return longint'(bus.dcoff_1b);
        endcase
    endfunction

    // Drives one calibration from the current negedge; abort_c/restart_c < 0 disable those events.
    task automatic run_cal(input string name, input int kreq, input int keff, input int vper,
                           input int v0, input int v1, input int v2, input int v3,
                           input bit alt, input int abort_c, input int restart_c);
        int     n = 1 << keff;
        int     cv[4];
        int     acc_n = 0;
        int     exp_c = -1;
        int     done_c = -1;
        bit     ph = 1'b0;
        logic   valid;
        longint sum;
        exp_t   e;
        int     limit;
        cv[0] = v0; cv[1] = v1; cv[2] = v2; cv[3] = v3;
        for (int i = 0; i < 4; i++) begin
            sum = (alt && i == 0) ? longint'(n / 2 * 7) : longint'(cv[i]) * n;
            e.corr[i] = model_corr(sum, keff);
            e.sat[i]  = (model_mean(sum, keff) == -32768);
        end
        if (abort_c < 0) sb.push_back(e);
        limit = (abort_c < 0) ? S + n * vper + 40 : abort_c + 12;

        for (int c = 0; c < limit; c++) begin
            if (c > 0) begin
                @(negedge sys_clk);
                cal_start = 1'b0;
                cal_abort = 1'b0;
                if (c == 1) check({name, " busy after start"}, cal_busy, 1);
                if (cal_done || bus.dcoff_load) begin
                    done_c = c;
                    break;
                end
            end
            if (c == 0) begin
                cal_start = 1'b1;
                mif_cal_k = 5'(kreq);
            end
            if (c == restart_c) begin
                cal_start = 1'b1;
                mif_cal_k = 5'd31;
            end
            if (c == abort_c) cal_abort = 1'b1;
            valid = (c % vper == 0);
            bus.adc_valid = valid;
            bus.adc_0a = alt ? (ph ? 16'sd4 : 16'sd3) : 16'(cv[0]);
            bus.adc_0b = 16'(cv[1]);
            bus.adc_1a = 16'(cv[2]);
            bus.adc_1b = 16'(cv[3]);
            if (valid) ph = ~ph;
            if (valid && c >= S + 1 && acc_n < n) begin
                acc_n++;
                if (acc_n == n) exp_c = c + 3;
            end
        end

        if (abort_c < 0) begin
            check({name, " done cycle"}, done_c, exp_c);
            if (sb.size() > 0) e = sb.pop_front();
            for (int i = 0; i < 4; i++)
                check($sformatf("%s dcoff[%0d]", name, i), dcoff(i), longint'($signed(e.corr[i])));
            check({name, " cal_sat"}, cal_sat, e.sat);
            check({name, " dcoff_load"}, bus.dcoff_load, 1);
            check({name, " cal_done"}, cal_done, 1);
            check({name, " dcoff_sel"}, bus.dcoff_sel, 1);
            e_last = e;
            @(negedge sys_clk);
            check({name, " done pulse width"}, cal_done, 0);
            check({name, " busy after done"}, cal_busy, 0);
        end else begin
            check({name, " no pulse after abort"}, done_c, -1);
            check({name, " busy after abort"}, cal_busy, 0);
            for (int i = 0; i < 4; i++)
                check($sformatf("%s kept dcoff[%0d]", name, i), dcoff(i), longint'($signed(e_last.corr[i])));
            check({name, " kept cal_sat"}, cal_sat, e_last.sat);
            check({name, " kept dcoff_sel"}, bus.dcoff_sel, 1);
        end
    endtask

    initial begin
        bus.adc_valid = 1'b0;
        bus.adc_0a = '0; bus.adc_0b = '0; bus.adc_1a = '0; bus.adc_1b = '0;
        repeat (3) @(negedge sys_clk);
        check("reset busy", cal_busy, 0);
        check("reset done", cal_done, 0);
        check("reset sat", cal_sat, 0);
        check("reset load", bus.dcoff_load, 0);
        check("reset sel", bus.dcoff_sel, 0);
        check("reset dcoff_0a", bus.dcoff_0a, 0);
        check("reset dcoff_1b", bus.dcoff_1b, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        run_cal("const100", 4, 4, 1, 100, 100, 100, 100, 1'b0, -1, -1);
        run_cal("half_up", 5, 5, 1, 0, -7, 0, 0, 1'b1, -1, -1);
        run_cal("saturate", 4, 4, 1, 0, 0, 32767, -32768, 1'b0, -1, -1);
        run_cal("sparse_valid", 6, 6, 3, 1000, -1234, 12, -1, 1'b0, -1, -1);
        run_cal("offset5", 4, 4, 1, -5, -5, -5, -5, 1'b0, -1, -1);
        run_cal("abort_accum", 4, 4, 1, 200, 200, 200, 200, 1'b0, S + 5, -1);
        run_cal("start_busy", 4, 4, 1, 9, 9, 9, 9, 1'b0, -1, 30);
        run_cal("k_clamp_lo", 0, 4, 1, 1, 2, -2, -1, 1'b0, -1, 20);
        run_cal("k_clamp_hi", 31, 16, 1, 1000, -1000, 7, -7, 1'b0, -1, -1);

        // Asynchronous reset in the middle of an accumulation.
        cal_start = 1'b1;
        mif_cal_k = 5'd4;
        bus.adc_valid = 1'b1;
        @(negedge sys_clk);
        cal_start = 1'b0;
        repeat (S + 3) @(negedge sys_clk);
        check("pre-reset busy", cal_busy, 1);
        sys_rst_n = 1'b0;
        #1;
        check("async rst busy", cal_busy, 0);
        check("async rst sel", bus.dcoff_sel, 0);
        check("async rst dcoff_0a", bus.dcoff_0a, 0);
        check("async rst dcoff_0b", bus.dcoff_0b, 0);
        check("async rst dcoff_1a", bus.dcoff_1a, 0);
        check("async rst dcoff_1b", bus.dcoff_1b, 0);
        check("async rst sat", cal_sat, 0);
        check("async rst load", bus.dcoff_load, 0);
        check("async rst done", cal_done, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("post-reset idle", cal_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
